// File: rtl/tile_loader_pkg.sv
// tile_loader_pkg: shared types and constants for the tile loader.
//   state_e         load sequencer states
//   KERNEL_SEL_BIT  a_input bit that selects kernel memory on the chip
//   *_ADDR_W        address field widths of the three receiving memories
//   max3()          helper used to size the shared address counter
package tile_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LD_IN,
      LD_K,
      LD_OV,
      READY
   } state_e;

   localparam int unsigned KERNEL_SEL_BIT = 15;
   localparam int unsigned IN_ADDR_W      = 14;
   localparam int unsigned K_ADDR_W       = 9;
   localparam int unsigned OV_ADDR_W      = 8;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/tile_loader.sv
// tile_loader: host-side transmitter that streams a valid/ready word flow into
// the accelerator's input feature-map memory, kernel memory and overlap cache
// (in that order), then raises data_ready until the chip reports fsm_done.
//
// Ports
//   clk, rst_in        clock, synchronous active-high reset
//   load_start         one-cycle pass request (honoured only in IDLE)
//   s_data/s_valid     host word stream
//   s_ready            loader accepts a word this cycle (from state only)
//   a_input/b_input    registered write address / data to the chip
//   int_mem_we         input/kernel memory write strobe (one per accept)
//   overlap_cache_we   overlap-cache write strobe (one per accept)
//   data_ready         all memories loaded; high for the whole READY state
//   fsm_done           chip finished its pass
//   busy               high in any state other than IDLE
//   checksum           running modulo-2^W sum of accepted words
//
// Build option: define TILE_LOADER_CHECKSUM_EN to build the checksum register;
// otherwise checksum is tied to zero.
module tile_loader
   import tile_loader_pkg::*;
#(
   parameter int unsigned IO_DATA_WIDTH = 16,
   parameter int unsigned INPUT_WORDS   = 16384,
   parameter int unsigned KERNEL_WORDS  = 512,
   parameter int unsigned OVERLAP_WORDS = 256
) (
   input  logic                     clk,
   input  logic                     rst_in,
   input  logic                     load_start,
   input  logic [IO_DATA_WIDTH-1:0] s_data,
   input  logic                     s_valid,
   output logic                     s_ready,
   output logic [IO_DATA_WIDTH-1:0] a_input,
   output logic [IO_DATA_WIDTH-1:0] b_input,
   output logic                     int_mem_we,
   output logic                     overlap_cache_we,
   output logic                     data_ready,
   input  logic                     fsm_done,
   output logic                     busy,
   output logic [IO_DATA_WIDTH-1:0] checksum
);

   localparam int unsigned MAX_WORDS = max3(INPUT_WORDS, KERNEL_WORDS, OVERLAP_WORDS);
   localparam int unsigned CNT_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

   localparam logic [CNT_W-1:0] IN_LAST = CNT_W'(INPUT_WORDS - 1);
   localparam logic [CNT_W-1:0] K_LAST  = CNT_W'(KERNEL_WORDS - 1);
   localparam logic [CNT_W-1:0] OV_LAST = CNT_W'(OVERLAP_WORDS - 1);

   state_e                   state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [IO_DATA_WIDTH-1:0] a_q, a_d;
   logic [IO_DATA_WIDTH-1:0] b_q, b_d;
   logic                     imwe_q, imwe_d;
   logic                     ovwe_q, ovwe_d;
   logic                     accept;

   assign s_ready = (state_q == LD_IN) || (state_q == LD_K) || (state_q == LD_OV);
   assign accept  = s_valid & s_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      imwe_d  = 1'b0;
      ovwe_d  = 1'b0;

      if (accept) begin
         b_d = s_data;
      end

      case (state_q)
         IDLE: begin
            if (load_start) state_d = LD_IN;
         end
         LD_IN: begin
            if (accept) begin
               a_d                  = '0;
               a_d[IN_ADDR_W-1:0]   = IN_ADDR_W'(cnt_q);
               imwe_d               = 1'b1;
               if (cnt_q == IN_LAST) begin
                  cnt_d   = '0;
                  state_d = LD_K;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         LD_K: begin
            if (accept) begin
               a_d                 = '0;
               a_d[KERNEL_SEL_BIT] = 1'b1;
               a_d[K_ADDR_W-1:0]   = K_ADDR_W'(cnt_q);
               imwe_d              = 1'b1;
               if (cnt_q == K_LAST) begin
                  cnt_d   = '0;
                  state_d = LD_OV;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         LD_OV: begin
            if (accept) begin
               a_d                = '0;
               a_d[OV_ADDR_W-1:0] = OV_ADDR_W'(cnt_q);
               ovwe_d             = 1'b1;
               if (cnt_q == OV_LAST) begin
                  cnt_d   = '0;
                  state_d = READY;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         READY: begin
            // A load_start coinciding with fsm_done is dropped: it is only
            // looked at from IDLE.
            if (fsm_done) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_in) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         imwe_q  <= 1'b0;
         ovwe_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         imwe_q  <= imwe_d;
         ovwe_q  <= ovwe_d;
      end
   end

   assign a_input          = a_q;
   assign b_input          = b_q;
   assign int_mem_we       = imwe_q;
   assign overlap_cache_we = ovwe_q;
   // data_ready follows READY exactly: first cycle after the final overlap
   // strobe up to and including the cycle fsm_done is sampled.
   assign data_ready       = (state_q == READY);
   assign busy             = (state_q != IDLE);

`ifdef TILE_LOADER_CHECKSUM_EN
   logic [IO_DATA_WIDTH-1:0] ck_q, ck_d;

   always_comb begin
      ck_d = ck_q;
      if ((state_q == IDLE) && load_start) begin
         ck_d = '0;
      end else if (accept) begin
         ck_d = ck_q + s_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_in) begin
         ck_q <= '0;
      end else begin
         ck_q <= ck_d;
      end
   end

   assign checksum = ck_q;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_tile_loader.sv
// tb_tile_loader: directed-vector bench for tile_loader with small regions
// (4 input, 2 kernel, 2 overlap words). Each vector holds the inputs driven
// before a clock edge and the outputs expected just after it.
module tb_tile_loader;

   logic        clk = 1'b0;
   logic        rst_in, load_start, s_valid, fsm_done;
   logic [15:0] s_data;
   logic        s_ready, int_mem_we, overlap_cache_we, data_ready, busy;
   logic [15:0] a_input, b_input, checksum;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   typedef struct {
      logic        rst, ld, fd, sv;
      logic [15:0] sd;
      logic        sr, imwe, ovwe, dr, bsy;
      logic [15:0] a, b, ck;
   } vec_t;

   tile_loader #(
      .IO_DATA_WIDTH (16),
      .INPUT_WORDS   (4),
      .KERNEL_WORDS  (2),
      .OVERLAP_WORDS (2)
   ) dut (
      .clk              (clk),
      .rst_in           (rst_in),
      .load_start       (load_start),
      .s_data           (s_data),
      .s_valid          (s_valid),
      .s_ready          (s_ready),
      .a_input          (a_input),
      .b_input          (b_input),
      .int_mem_we       (int_mem_we),
      .overlap_cache_we (overlap_cache_we),
      .data_ready       (data_ready),
      .fsm_done         (fsm_done),
      .busy             (busy),
      .checksum         (checksum)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic rst, input logic ld, input logic fd,
                               input logic sv, input logic [15:0] sd,
                               input logic sr, input logic imwe, input logic ovwe,
                               input logic dr, input logic bsy,
                               input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] ck);
      vec_t v;
      v.rst = rst; v.ld = ld; v.fd = fd; v.sv = sv; v.sd = sd;
      v.sr = sr; v.imwe = imwe; v.ovwe = ovwe; v.dr = dr; v.bsy = bsy;
      v.a = a; v.b = b; v.ck = ck;
      return v;
   endfunction

   task automatic apply(input string tag, input int idx, input vec_t v);
      logic [15:0] exp_ck;
      rst_in     = v.rst;
      load_start = v.ld;
      fsm_done   = v.fd;
      s_valid    = v.sv;
      s_data     = v.sd;
      @(posedge clk);
      #1;
`ifdef TILE_LOADER_CHECKSUM_EN
      exp_ck = v.ck;
`else
      exp_ck = 16'h0000;
`endif
      n_vec++;
      if (s_ready !== v.sr || int_mem_we !== v.imwe || overlap_cache_we !== v.ovwe ||
          data_ready !== v.dr || busy !== v.bsy || a_input !== v.a ||
          b_input !== v.b || checksum !== exp_ck) begin
         n_bad++;
         $display("FAIL %s[%0d]: got sr=%b imwe=%b ovwe=%b dr=%b busy=%b a=%h b=%h ck=%h, expected sr=%b imwe=%b ovwe=%b dr=%b busy=%b a=%h b=%h ck=%h",
                  tag, idx, s_ready, int_mem_we, overlap_cache_we, data_ready, busy,
                  a_input, b_input, checksum, v.sr, v.imwe, v.ovwe, v.dr, v.bsy,
                  v.a, v.b, exp_ck);
      end
   endtask

   initial begin
      vec_t        nom [13];
      logic [15:0] exp_addr [8];
      logic [15:0] pa, pb, sum, d;
      logic        last;

      exp_addr = '{16'h0000, 16'h0001, 16'h0002, 16'h0003,
                   16'h8000, 16'h8001, 16'h0000, 16'h0001};

      // Nominal pass, s_valid always high, data 1..8; ends with a load_start
      // in READY (ignored) and the fsm_done handoff.
      nom[0]  = mk(0,1,0,0,16'h0000, 1,0,0,0,1, 16'h0000,16'h0000,16'd0);
      nom[1]  = mk(0,0,0,1,16'h0001, 1,1,0,0,1, 16'h0000,16'h0001,16'd1);
      nom[2]  = mk(0,0,0,1,16'h0002, 1,1,0,0,1, 16'h0001,16'h0002,16'd3);
      nom[3]  = mk(0,0,0,1,16'h0003, 1,1,0,0,1, 16'h0002,16'h0003,16'd6);
      nom[4]  = mk(0,0,0,1,16'h0004, 1,1,0,0,1, 16'h0003,16'h0004,16'd10);
      nom[5]  = mk(0,0,0,1,16'h0005, 1,1,0,0,1, 16'h8000,16'h0005,16'd15);
      nom[6]  = mk(0,0,0,1,16'h0006, 1,1,0,0,1, 16'h8001,16'h0006,16'd21);
      nom[7]  = mk(0,0,0,1,16'h0007, 1,0,1,0,1, 16'h0000,16'h0007,16'd28);
      nom[8]  = mk(0,0,0,1,16'h0008, 0,0,1,1,1, 16'h0001,16'h0008,16'h0024);
      nom[9]  = mk(0,0,0,0,16'h0000, 0,0,0,1,1, 16'h0001,16'h0008,16'h0024);
      nom[10] = mk(0,1,0,1,16'h0055, 0,0,0,1,1, 16'h0001,16'h0008,16'h0024);
      nom[11] = mk(0,0,1,0,16'h0000, 0,0,0,0,0, 16'h0001,16'h0008,16'h0024);
      nom[12] = mk(0,0,0,0,16'h0000, 0,0,0,0,0, 16'h0001,16'h0008,16'h0024);

      rst_in = 1'b1; load_start = 1'b0; fsm_done = 1'b0; s_valid = 1'b0; s_data = '0;

      // Reset and idle
      for (int i = 0; i < 2; i++)
         apply("reset", i, mk(1,0,0,0,16'h0000, 0,0,0,0,0, 16'h0,16'h0,16'h0));
      for (int i = 0; i < 20; i++)
         apply("idle", i, mk(0,0,0,i[0],16'h1234, 0,0,0,0,0, 16'h0,16'h0,16'h0));

      // Nominal pass from the table
      for (int i = 0; i < 13; i++)
         apply("nominal", i, nom[i]);

      // Stalled pass: a bubble before every word
      pa = 16'h0001; pb = 16'h0008; sum = 16'h0000;
      apply("stall_start", 0, mk(0,1,0,0,16'h0000, 1,0,0,0,1, pa,pb,sum));
      for (int w = 0; w < 8; w++) begin
         apply("stall_bubble", w, mk(0,0,0,0,16'hDEAD, 1,0,0,0,1, pa,pb,sum));
         d    = 16'hA000 + 16'(w);
         sum  = sum + d;
         last = (w == 7);
         apply("stall_word", w, mk(0,0,0,1,d, !last, (w < 6), (w >= 6), last, 1'b1,
                                   exp_addr[w], d, sum));
         pa = exp_addr[w];
         pb = d;
      end

      // Handoff: long wait in READY with an ignored load_start and host word
      for (int c = 0; c < 50; c++)
         apply("handoff_wait", c, mk(0,(c == 10),0,(c == 20),16'h0077, 0,0,0,1,1, pa,pb,sum));
      apply("handoff_done", 0, mk(0,0,1,0,16'h0000, 0,0,0,0,0, pa,pb,sum));
      apply("handoff_idle", 0, mk(0,0,0,0,16'h0000, 0,0,0,0,0, pa,pb,sum));

      // Reset after the third input-region accept
      apply("midrst_start", 0, mk(0,1,0,0,16'h0000, 1,0,0,0,1, pa,pb,16'h0000));
      apply("midrst_word", 0, mk(0,0,0,1,16'h0010, 1,1,0,0,1, 16'h0000,16'h0010,16'h0010));
      apply("midrst_word", 1, mk(0,0,0,1,16'h0011, 1,1,0,0,1, 16'h0001,16'h0011,16'h0021));
      apply("midrst_word", 2, mk(0,0,0,1,16'h0012, 1,1,0,0,1, 16'h0002,16'h0012,16'h0033));
      apply("midrst_rst", 0, mk(1,0,0,1,16'h0013, 0,0,0,0,0, 16'h0,16'h0,16'h0));
      apply("midrst_after", 0, mk(0,0,0,1,16'h0014, 0,0,0,0,0, 16'h0,16'h0,16'h0));
      apply("midrst_restart", 0, mk(0,1,0,0,16'h0000, 1,0,0,0,1, 16'h0,16'h0,16'h0));
      apply("midrst_first", 0, mk(0,0,0,1,16'h0020, 1,1,0,0,1, 16'h0000,16'h0020,16'h0020));

      // All-ones pass for checksum wrap; ends with load_start and fsm_done together
      apply("ones_rst", 0, mk(1,0,0,0,16'h0000, 0,0,0,0,0, 16'h0,16'h0,16'h0));
      apply("ones_start", 0, mk(0,1,0,0,16'h0000, 1,0,0,0,1, 16'h0,16'h0,16'h0));
      sum = 16'h0000;
      for (int w = 0; w < 8; w++) begin
         sum  = sum + 16'hFFFF;
         last = (w == 7);
         apply("ones_word", w, mk(0,0,0,1,16'hFFFF, !last, (w < 6), (w >= 6), last, 1'b1,
                                  exp_addr[w], 16'hFFFF, sum));
      end
      apply("ones_sum", 0, mk(0,0,0,0,16'h0000, 0,0,0,1,1, 16'h0001,16'hFFFF,16'hFFF8));
      apply("start_with_done", 0, mk(0,1,1,0,16'h0000, 0,0,0,0,0, 16'h0001,16'hFFFF,16'hFFF8));
      apply("start_dropped", 0, mk(0,0,0,1,16'h0000, 0,0,0,0,0, 16'h0001,16'hFFFF,16'hFFF8));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
